// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control with a
// return-address stack, stall support and signed PC-relative branches.
module fetch_unit #(
  parameter int unsigned PW         = 16,
  parameter int unsigned OW         = 8,
  parameter int unsigned RAS_DEPTH  = 4,
  parameter int unsigned START_ADDR = 0,
  localparam int unsigned CW        = $clog2(RAS_DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          Branch_abs,
  input  logic          Branch_rel_en,
  input  logic          ALU_zero,
  input  logic [PW-1:0] Target,
  input  logic [OW-1:0] Offset,
  input  logic          Call,
  input  logic          Ret,
  output logic [PW-1:0] PC,
  output logic          Running,
  output logic [CW-1:0] Ras_count,
  output logic          Ras_ovf,
  output logic          Ras_unf,
  output logic [1:0]    dbg_state
);

  localparam int unsigned IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] pc_inc, rel_target;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          running_q;
  logic          push_en;
  logic          stack_full, stack_empty;
  logic [IW-1:0] push_idx, top_idx;
  logic [PW-1:0] ras_mem [RAS_DEPTH];

  assign pc_inc      = pc_q + PW'(1);
  assign rel_target  = pc_q + PW'($signed(Offset));
  assign stack_full  = (cnt_q == CW'(RAS_DEPTH));
  assign stack_empty = (cnt_q == '0);
  assign push_idx    = IW'(cnt_q);
  assign top_idx     = IW'(cnt_q - CW'(1));

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Start) state_d = S_RUN;
      S_RUN:    if (Halt)  state_d = S_HALTED;
      S_HALTED: if (Start) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control-flow strobes are level inputs sampled at each edge; in RUN the
  // priority is Halt > Stall > Ret > Call > Branch_abs > relative branch.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    case (state_q)
      S_RUN: begin
        if (!Halt && !Stall) begin
          if (Ret) begin
            if (!stack_empty) begin
              pc_d  = ras_mem[top_idx];
              cnt_d = cnt_q - CW'(1);
            end else begin
              pc_d  = pc_inc;
              unf_d = 1'b1;
            end
          end else if (Call) begin
            pc_d = Target;
            if (!stack_full) begin
              push_en = 1'b1;
              cnt_d   = cnt_q + CW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (Branch_abs) begin
            pc_d = Target;
          end else if (Branch_rel_en && ALU_zero) begin
            pc_d = rel_target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      S_HALTED: begin
        if (Start) begin
          pc_d  = PW'(START_ADDR);
          cnt_d = '0;
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q      <= PW'(START_ADDR);
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      running_q <= (state_d == S_RUN);
    end
  end

  // Stack storage needs no reset: entries above cnt_q are never read.
  always_ff @(posedge CLK) begin
    if (push_en) ras_mem[push_idx] <= pc_inc;
  end

  assign PC        = pc_q;
  assign Running   = running_q;
  assign Ras_count = cnt_q;
  assign Ras_ovf   = ovf_q;
  assign Ras_unf   = unf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// cycles compared against a queue-based behavioural model.
module tb_fetch_unit;

  localparam int PW = 16;
  localparam int OW = 8;
  localparam int RAS_DEPTH = 4;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic          CLK = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0, Halt = 1'b0, Stall = 1'b0;
  logic          Branch_abs = 1'b0, Branch_rel_en = 1'b0, ALU_zero = 1'b0;
  logic [PW-1:0] Target = '0;
  logic [OW-1:0] Offset = '0;
  logic          Call = 1'b0, Ret = 1'b0;
  logic [PW-1:0] PC;
  logic          Running;
  logic [CW-1:0] Ras_count;
  logic          Ras_ovf, Ras_unf;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  // behavioural model: 0=IDLE 1=RUN 2=HALTED
  int            m_state;
  logic [PW-1:0] m_pc;
  logic [PW-1:0] m_ras[$];
  logic          m_ovf, m_unf;

  fetch_unit #(.PW(PW), .OW(OW), .RAS_DEPTH(RAS_DEPTH), .START_ADDR(0)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Halt(Halt), .Stall(Stall),
    .Branch_abs(Branch_abs), .Branch_rel_en(Branch_rel_en), .ALU_zero(ALU_zero),
    .Target(Target), .Offset(Offset), .Call(Call), .Ret(Ret),
    .PC(PC), .Running(Running), .Ras_count(Ras_count),
    .Ras_ovf(Ras_ovf), .Ras_unf(Ras_unf), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_state = 0;
    m_pc    = '0;
    m_ras.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_step();
    case (m_state)
      0: if (Start) m_state = 1;
      1: begin
        if (Halt) m_state = 2;
        else if (Stall) ;
        else if (Ret) begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else begin m_pc = m_pc + 16'd1; m_unf = 1'b1; end
        end else if (Call) begin
          if (m_ras.size() < RAS_DEPTH) m_ras.push_back(m_pc + 16'd1);
          else m_ovf = 1'b1;
          m_pc = Target;
        end else if (Branch_abs) m_pc = Target;
        else if (Branch_rel_en && ALU_zero)
          m_pc = 16'(int'(m_pc) + int'($signed(Offset)));
        else m_pc = m_pc + 16'd1;
      end
      default: if (Start) begin
        m_state = 0; m_pc = '0; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end
    endcase
  endtask

  task automatic clear_inputs();
    Start = 0; Halt = 0; Stall = 0; Branch_abs = 0; Branch_rel_en = 0;
    ALU_zero = 0; Call = 0; Ret = 0; Target = '0; Offset = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset_n = 0;
    model_reset();
    @(posedge CLK);
    #1;
    Reset_n = 1;
  endtask

  task automatic jump_to(input logic [PW-1:0] t);
    Branch_abs = 1; Target = t; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (PC !== 16'd0 || Running !== 1'b0 || Ras_count !== '0 || Ras_ovf !== 1'b0 ||
        Ras_unf !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset: pc=%0d run=%0b cnt=%0d ovf=%0b unf=%0b st=%0d required 0 0 0 0 0 0",
               PC, Running, Ras_count, Ras_ovf, Ras_unf, dbg_state);
    end
  endtask

  task automatic test_start_seq();
    logic [PW-1:0] exp_pc [4] = '{16'd0, 16'd1, 16'd2, 16'd3};
    do_reset();
    Start = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (PC !== exp_pc[i] || Running !== 1'b1) begin
        failures++;
        $display("FAIL start_seq[%0d]: pc=%0d run=%0b required pc=%0d run=1", i, PC, Running, exp_pc[i]);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_rel_branch();
    do_reset();
    Start = 1; tick();
    jump_to(16'd10);
    Branch_rel_en = 1; ALU_zero = 1; Offset = 8'hFC; tick();
    checks++;
    if (PC !== 16'd6) begin failures++; $display("FAIL rel_taken: pc=%0d required 6", PC); end
    jump_to(16'd10);
    Branch_rel_en = 1; ALU_zero = 0; Offset = 8'hFC; tick();
    checks++;
    if (PC !== 16'd11) begin failures++; $display("FAIL rel_not_taken: pc=%0d required 11", PC); end
    jump_to(16'hFFF0);
    Branch_rel_en = 1; ALU_zero = 1; Offset = 8'h7F; tick();
    checks++;
    if (PC !== 16'h006F) begin failures++; $display("FAIL rel_wrap: pc=%h required 006f", PC); end
    jump_to(16'hFFFF);
    tick();
    checks++;
    if (PC !== 16'h0000) begin failures++; $display("FAIL pc_wrap: pc=%h required 0000", PC); end
  endtask

  task automatic test_ras();
    logic [PW-1:0] tgt [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    logic [PW-1:0] pops [4] = '{16'd301, 16'd201, 16'd101, 16'd6};
    do_reset();
    Start = 1; tick();
    jump_to(16'd5);
    for (int i = 0; i < 4; i++) begin
      Call = 1; Target = tgt[i]; tick();
      checks++;
      if (PC !== tgt[i] || Ras_count !== CW'(i + 1)) begin
        failures++;
        $display("FAIL call[%0d]: pc=%0d cnt=%0d required pc=%0d cnt=%0d", i, PC, Ras_count, tgt[i], i + 1);
      end
    end
    Call = 1; Target = 16'd500; tick();
    checks++;
    if (PC !== 16'd500 || Ras_ovf !== 1'b1 || Ras_count !== CW'(4)) begin
      failures++;
      $display("FAIL call_full: pc=%0d ovf=%0b cnt=%0d required 500 1 4", PC, Ras_ovf, Ras_count);
    end
    for (int i = 0; i < 4; i++) begin
      Ret = 1; tick();
      checks++;
      if (PC !== pops[i] || Ras_count !== CW'(3 - i)) begin
        failures++;
        $display("FAIL ret[%0d]: pc=%0d cnt=%0d required pc=%0d cnt=%0d", i, PC, Ras_count, pops[i], 3 - i);
      end
    end
    Ret = 1; tick();
    checks++;
    if (PC !== 16'd7 || Ras_unf !== 1'b1 || Ras_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ret_empty: pc=%0d unf=%0b ovf=%0b required 7 1 1", PC, Ras_unf, Ras_ovf);
    end
    jump_to(16'hFFFF);
    Call = 1; Target = 16'd3; tick();
    Ret = 1; tick();
    checks++;
    if (PC !== 16'h0000 || Ras_count !== '0) begin
      failures++;
      $display("FAIL push_wrap: pc=%h cnt=%0d required 0000 0", PC, Ras_count);
    end
  endtask

  task automatic test_priority();
    do_reset();
    Start = 1; tick();
    jump_to(16'd6);
    Call = 1; Target = 16'd20; tick();
    Stall = 1; Branch_abs = 1; Target = 16'd50; tick();
    checks++;
    if (PC !== 16'd20 || Running !== 1'b1) begin
      failures++;
      $display("FAIL stall_prio: pc=%0d run=%0b required 20 1", PC, Running);
    end
    Ret = 1; Call = 1; Target = 16'd99; tick();
    checks++;
    if (PC !== 16'd7 || Ras_count !== '0) begin
      failures++;
      $display("FAIL ret_over_call: pc=%0d cnt=%0d required 7 0", PC, Ras_count);
    end
    jump_to(16'd20);
    Halt = 1; Branch_abs = 1; Target = 16'd50; tick();
    checks++;
    if (PC !== 16'd20 || Running !== 1'b0 || dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL halt_prio: pc=%0d run=%0b st=%0d required 20 0 2", PC, Running, dbg_state);
    end
    Halt = 1; Branch_abs = 1; Target = 16'd50; tick();
    checks++;
    if (PC !== 16'd20 || dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL halted_frozen: pc=%0d st=%0d required 20 2", PC, dbg_state);
    end
  endtask

  task automatic test_restart();
    do_reset();
    Start = 1; tick();
    Ret = 1; tick();
    for (int i = 0; i < 5; i++) begin Call = 1; Target = 16'd200; tick(); end
    jump_to(16'd33);
    Halt = 1; tick();
    checks++;
    if (PC !== 16'd33 || Ras_ovf !== 1'b1 || Ras_unf !== 1'b1 || dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL pre_restart: pc=%0d ovf=%0b unf=%0b st=%0d required 33 1 1 2", PC, Ras_ovf, Ras_unf, dbg_state);
    end
    Start = 1; tick();
    checks++;
    if (PC !== 16'd0 || Ras_count !== '0 || Ras_ovf !== 1'b0 || Ras_unf !== 1'b0 ||
        dbg_state !== 2'd0 || Running !== 1'b0) begin
      failures++;
      $display("FAIL restart: pc=%0d cnt=%0d ovf=%0b unf=%0b st=%0d run=%0b required 0 0 0 0 0 0",
               PC, Ras_count, Ras_ovf, Ras_unf, dbg_state, Running);
    end
    Start = 1; tick();
    checks++;
    if (Running !== 1'b1 || PC !== 16'd0) begin
      failures++;
      $display("FAIL restart_run: run=%0b pc=%0d required 1 0", Running, PC);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    Start = 1; tick();
    jump_to(16'd40);
    @(negedge CLK);
    Reset_n = 0;
    model_reset();
    #1;
    checks++;
    if (PC !== 16'd0 || Running !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: pc=%0d run=%0b st=%0d required 0 0 0", PC, Running, dbg_state);
    end
    #2;
    Reset_n = 1;
    tick(); tick();
    checks++;
    if (PC !== 16'd0 || Running !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_idle: pc=%0d run=%0b st=%0d required 0 0 0", PC, Running, dbg_state);
    end
  endtask

  task automatic test_random();
    do_reset();
    Start = 1; tick();
    for (int i = 0; i < 500; i++) begin
      Start         = ($urandom_range(0, 11) == 0);
      Halt          = ($urandom_range(0, 39) == 0);
      Stall         = ($urandom_range(0, 7) == 0);
      Ret           = ($urandom_range(0, 4) == 0);
      Call          = ($urandom_range(0, 4) == 0);
      Branch_abs    = ($urandom_range(0, 7) == 0);
      Branch_rel_en = ($urandom_range(0, 3) == 0);
      ALU_zero      = 1'($urandom_range(0, 1));
      Target        = 16'($urandom_range(0, 65535));
      Offset        = 8'($urandom_range(0, 255));
      tick();
      checks++;
      if (PC !== m_pc || Running !== (m_state == 1) || Ras_count !== CW'(m_ras.size()) ||
          Ras_ovf !== m_ovf || Ras_unf !== m_unf || dbg_state !== 2'(m_state)) begin
        failures++;
        $display("FAIL random[%0d]: pc=%h run=%0b cnt=%0d ovf=%0b unf=%0b st=%0d required pc=%h run=%0b cnt=%0d ovf=%0b unf=%0b st=%0d",
                 i, PC, Running, Ras_count, Ras_ovf, Ras_unf, dbg_state,
                 m_pc, (m_state == 1), m_ras.size(), m_ovf, m_unf, m_state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_seq();
    test_rel_branch();
    test_ras();
    test_priority();
    test_restart();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised program counter and fetch sequencer for the basic processor. Next generation of the single-width PC block.
- Adds configurable PC width, signed PC-relative branches, a hardware return-address stack for call/return, stall support, and an explicit IDLE/RUN/HALTED state machine.
- Sits between control decode (branch, call and return strobes), the ALU (zero flag) and the instruction memory address port.

Parameters:
- PW, 16, PC and Target width in bits.
- OW, 8, width of the signed relative-branch offset.
- RAS_DEPTH, 4, return-address stack entries (>=1).
- START_ADDR, 0, PC value loaded on reset and on restart.

Ports:
- CLK  in  1  clock; all state changes on posedge only.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  IDLE->RUN; HALTED->IDLE (re-init).
- Halt  in  1  freeze PC and enter HALTED.
- Stall  in  1  hold PC for this cycle (RUN only).
- Branch_abs  in  1  unconditional jump to Target.
- Branch_rel_en  in  1  conditional relative jump, taken when ALU_zero=1.
- ALU_zero  in  1  ALU zero flag.
- Target  in  PW  absolute jump/call destination.
- Offset  in  OW  signed two's-complement relative displacement.
- Call  in  1  push PC+1, jump to Target.
- Ret  in  1  pop return address into PC.
- PC  out  PW  current program counter.
- Running  out  1  1 when in RUN.
- Ras_count  out  $clog2(RAS_DEPTH+1)  valid stack entries.
- Ras_ovf  out  1  sticky: Call with stack full.
- Ras_unf  out  1  sticky: Ret with stack empty.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State=IDLE, PC=START_ADDR, Running=0.
  - Ras_count=0, Ras_ovf=0, Ras_unf=0; stack contents don't-care.
- IDLE:
  - PC held.
  - Start=1 -> RUN next edge; PC unchanged (first fetch at START_ADDR).
- RUN, evaluated each posedge, first match wins:
  1. Halt=1 -> HALTED; PC, stack and flags unchanged. Halt beats Stall and all control-flow inputs in the same cycle.
  2. Stall=1 -> all state held.
  3. Ret=1:
     - Stack non-empty: PC<=top entry, Ras_count-1.
     - Stack empty: PC<=PC+1, Ras_unf<=1.
  4. Call=1:
     - Not full: push PC+1, PC<=Target, Ras_count+1.
     - Full: PC<=Target, no push, Ras_ovf<=1; existing entries preserved.
  5. Branch_abs=1 -> PC<=Target.
  6. Branch_rel_en=1 and ALU_zero=1 -> PC<=PC+sign_extend(Offset), modulo 2^PW.
  7. Otherwise PC<=PC+1, modulo 2^PW; PC=2^PW-1 wraps to 0.
- Branch_rel_en=1 with ALU_zero=0 -> falls through to PC+1.
- Pushed return address PC+1 also wraps modulo 2^PW.
- HALTED:
  - PC frozen; Running=0.
  - Start=1 -> IDLE with PC<=START_ADDR, Ras_count<=0, flags cleared.
  - Halt is ignored in HALTED.
- Running is registered and equals (state==RUN). PC is a registered output, with zero combinational paths from inputs to outputs.
- Ras_ovf and Ras_unf clear only on reset or on restart from HALTED.
- Reset asserted mid-operation aborts immediately to reset values, regardless of state or strobes.

Test Plan:
- Reset then Start, 3 idle cycles -> PC sequence 0,0,1,2,3; Running=1 from the cycle after Start.
- RUN at PC=10, Branch_rel_en=1, ALU_zero=1, Offset=8'hFC -> PC=6. Repeat with ALU_zero=0 -> PC=11. Offset=8'h7F from PC=16'hFFF0 -> PC=16'h006F (wrap).
- RAS_DEPTH=4:
  - Call Target=100 at PC=5 -> PC=100, Ras_count=1.
  - Three more nested Calls -> Ras_count=4.
  - Fifth Call -> PC=Target, Ras_ovf=1, Ras_count=4.
  - Four Rets -> PCs pop in LIFO order, ending at 6.
  - Fifth Ret -> PC+1, Ras_unf=1.
- Same-cycle priority at PC=20:
  - Halt+Branch_abs(Target=50) -> PC stays 20, state HALTED.
  - Ret+Call with stack holding 7 -> PC=7.
  - Stall+Branch_abs -> PC stays 20.
- HALTED with PC=33, flags set -> Start -> IDLE, PC=START_ADDR, Ras_count=0, flags 0. Second Start -> RUN.
- Reset_n pulsed low between clock edges during RUN at PC=40 -> PC=0 and Running=0 immediately (no clock edge needed); stays IDLE after release.
